if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline stage register for the 5-stage MIPS pipeline, with integrated hazard control.
- Sits between the fetch logic (PC, instruction memory) and the decode stage / ID/EX flip-flop bank.
- Holds on load-use hazards and external stalls, and bubbles on taken branches.
- Drives the PC write enable and the ID/EX bubble control.

Parameters:
- DW, 32, datapath/instruction width.
- RW, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- pc4_in  in  DW  PC+4 from fetch.
- instr_in  in  DW  fetched instruction.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rt  in  RW  destination rt of the instruction in ID/EX.
- branch_taken  in  1  taken branch/jump resolved downstream; fetch path is wrong.
- ext_stall  in  1  global freeze (e.g. memory not ready).
- pc4_out  out  DW  registered PC+4 to decode.
- instr_out  out  DW  registered instruction to decode.
- valid_out  out  1  instr_out is a real instruction.
- pc_write  out  1  PC register enable (combinational).
- idex_bubble  out  1  force ID/EX control fields to zero this cycle (combinational).

Behaviour:
- Reset (rst=0 at posedge): pc4_out=0, instr_out=0 (NOP), valid_out=0, state=RUN, flush_pending=0.
- While rst=0: pc_write=0, idex_bubble=1.
- Latency: one cycle, pc4_in/instr_in to pc4_out/instr_out.
- Load-use hazard (lu), combinational; all terms required:
  - valid_out=1.
  - idex_memread=1.
  - idex_rt!=0.
  - idex_rt==instr_out[25:21], or (idex_rt==instr_out[20:16] and opcode instr_out[31:26] in {000000, 000100, 000101, 101011}).
- FSM states:
  - RUN: normal operation; lu is evaluated here.
  - LU_STALL: exactly one cycle; lu masked; returns to RUN.
- Per-cycle priority, highest first:
  1. Reset.
  2. Flush, when (branch_taken or flush_pending) and ext_stall=0:
     - instr_out<=0, pc4_out<=0, valid_out<=0.
     - idex_bubble=1, pc_write=1 (PC loads the target).
     - flush_pending<=0, state<=RUN.
  3. ext_stall=1:
     - All registers hold; pc_write=0; idex_bubble=0; state holds.
     - If branch_taken=1, flush_pending<=1.
  4. lu in RUN:
     - IF/ID holds; pc_write=0; idex_bubble=1; state<=LU_STALL.
  5. Normal: IF/ID loads inputs, valid_out<=1, pc_write=1, idex_bubble=0; state<=RUN.
- Boundary cases:
  - Flush while in LU_STALL: flush wins, state<=RUN.
  - branch_taken and lu in the same cycle: flush wins, no stall cycle.
  - Multiple branch_taken pulses during one ext_stall: a single flush.
  - Reset mid-stall or with flush pending: clears everything.
  - idex_rt==0 never stalls.
  - Loads/stores use rt as the load destination and as store data. Only the store opcode (101011) is rt-sensitive among memory ops; a load in ID (100011) compares rs only.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] (increments each cycle pc_write=0 with rst=1) and flush_count[31:0] (increments per applied flush).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mips_pipe_pkg:
  - Opcode constants: OP_RTYPE=6'b000000, OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_SW=6'b101011, OP_LW=6'b100011.
  - NOP_INSTR=32'h0000_0000.
  - State encoding: RUN=1'b0, LU_STALL=1'b1.
- Sub-module load_use_detect: purely combinational. Inputs valid, instr, idex_memread, idex_rt; output lu. It is reused by later forwarding work.

Test Plan:
- Reset/pass-through:
  - Stimulus: rst=0 for 2 cycles, then rst=1 with instr_in=32'h8C08_0004, pc4_in=32'h0000_0004.
  - Response: outputs 0/valid_out=0 during reset; next cycle instr_out=32'h8C08_0004, pc4_out=4, valid_out=1.
- Load-use stall:
  - Stimulus: instr_out=32'h010A_4820 (add $9,$8,$10), idex_memread=1, idex_rt=8, held high for 2 cycles.
  - Response: pc_write=0 and idex_bubble=1 for exactly 1 cycle, IF/ID holds; the following cycle advances (masked).
- Zero register:
  - Stimulus: idex_rt=0, instr_out rs=0.
  - Response: no stall; pc_write=1.
- Branch flush:
  - Stimulus: branch_taken=1 for 1 cycle.
  - Response: idex_bubble=1 and pc_write=1 that cycle; next cycle instr_out=0, valid_out=0.
- Flush during freeze:
  - Stimulus: ext_stall=1 for 3 cycles, branch_taken pulsed in the 1st.
  - Response: outputs hold, pc_write=0 throughout; first cycle with ext_stall=0 flushes (valid_out<=0) with branch_taken=0.
- Simultaneous branch + load-use:
  - Stimulus: both conditions in the same cycle.
  - Response: flush only; pc_write=1, state stays RUN. With IF_ID_PERF_CNT_EN, flush_count increments by 1 and stall_cycles is unchanged.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: opcodes, the NOP encoding and the IF/ID hazard FSM states.
// Pure declarations; no timing and no flow control.
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } if_id_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in ID/EX whose destination is read by the instruction in decode.
// Purely combinational (zero latency); no flow control of its own.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          valid,
  input  logic [DW-1:0] instr,
  input  logic          idex_memread,
  input  logic [RW-1:0] idex_rt,
  output logic          lu
);

  logic [5:0] op;
  logic       reads_rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_imm;

  assign op = instr[31:26];

  // A load in decode writes rt rather than reading it, so only rs matters there.
  always_comb begin
    reads_rt = 1'b0;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: reads_rt = 1'b1;
      OP_LW:                           reads_rt = 1'b0;
      default:                         reads_rt = 1'b0;
    endcase
  end

  assign rs_hit = (idex_rt == instr[25:21]);
  assign rt_hit = (idex_rt == instr[20:16]) && reads_rt;

  assign lu = valid && idex_memread && (idex_rt != '0) && (rs_hit || rt_hit);

  assign unused_imm = ^instr[15:0];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID register with load-use stall, external freeze and branch flush; optional perf counters via IF_ID_PERF_CNT_EN.
// One cycle latency; holds on ext_stall/load-use, and a branch seen while frozen is flushed once the freeze lifts.
module if_id_stage
  import mips_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pc4_in,
  input  logic [DW-1:0] instr_in,
  input  logic          idex_memread,
  input  logic [RW-1:0] idex_rt,
  input  logic          branch_taken,
  input  logic          ext_stall,
  output logic [DW-1:0] pc4_out,
  output logic [DW-1:0] instr_out,
  output logic          valid_out,
  output logic          pc_write,
  output logic          idex_bubble
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_count
`endif
);

  if_id_state_t state;
  logic         flush_pending;
  logic         lu_raw;
  logic         lu;
  logic         flush;

  load_use_detect #(
    .DW(DW),
    .RW(RW)
  ) u_lu (
    .valid        (valid_out),
    .instr        (instr_out),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .lu           (lu_raw)
  );

  // The cycle after a load-use stall the load has moved on, so the hazard is masked.
  assign lu    = lu_raw && (state == RUN);
  assign flush = (branch_taken || flush_pending) && !ext_stall;

  assign pc_write    = rst && (flush || (!ext_stall && !lu));
  assign idex_bubble = !rst || flush || (!ext_stall && lu);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc4_out       <= '0;
      instr_out     <= DW'(NOP_INSTR);
      valid_out     <= 1'b0;
      flush_pending <= 1'b0;
      state         <= RUN;
    end else if (flush) begin
      pc4_out       <= '0;
      instr_out     <= DW'(NOP_INSTR);
      valid_out     <= 1'b0;
      flush_pending <= 1'b0;
      state         <= RUN;
    end else if (ext_stall) begin
      if (branch_taken) flush_pending <= 1'b1;
    end else if (lu) begin
      state <= LU_STALL;
    end else begin
      pc4_out   <= pc4_in;
      instr_out <= instr_in;
      valid_out <= 1'b1;
      state     <= RUN;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (flush && (flush_count != 32'hFFFF_FFFF))      flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized and directed bench for if_id_stage against a cycle-level reference model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc4_in = '0;
  logic [31:0] instr_in = '0;
  logic        idex_memread = 1'b0;
  logic [4:0]  idex_rt = '0;
  logic        branch_taken = 1'b0;
  logic        ext_stall = 1'b0;
  logic [31:0] pc4_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        pc_write;
  logic        idex_bubble;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  if_id_stage #(.DW(32), .RW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc4_in       (pc4_in),
    .instr_in     (instr_in),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .branch_taken (branch_taken),
    .ext_stall    (ext_stall),
    .pc4_out      (pc4_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .pc_write     (pc_write),
    .idex_bubble  (idex_bubble)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what decode currently holds, plus pending-flush and "just stalled" flags.
  logic [31:0] m_pc4, m_instr;
  bit          m_valid, m_fp, m_masked, m_known;
  bit          e_pcw, e_bub;
  longint      m_stalls, m_flushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hazard(input logic [31:0] ins, input bit v, input bit mr, input logic [4:0] rt);
    logic [5:0] op;
    bit reads_rt;
    op = ins[31:26];
    reads_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) || (op == 6'b101011);
    return v && mr && (rt != 5'd0) && ((rt == ins[25:21]) || (reads_rt && (rt == ins[20:16])));
  endfunction

  task automatic cyc(input bit r, input logic [31:0] pc, input logic [31:0] ins,
                     input bit mr, input logic [4:0] rt, input bit bt, input bit es);
    bit lu, fl;
    @(negedge clk);
    rst = r; pc4_in = pc; instr_in = ins; idex_memread = mr; idex_rt = rt;
    branch_taken = bt; ext_stall = es;
    #1;
    lu = !m_masked && hazard(m_instr, m_valid, mr, rt);
    fl = r && (bt || m_fp) && !es;
    if (!r)       begin e_pcw = 0; e_bub = 1; end
    else if (fl)  begin e_pcw = 1; e_bub = 1; end
    else if (es)  begin e_pcw = 0; e_bub = 0; end
    else if (lu)  begin e_pcw = 0; e_bub = 1; end
    else          begin e_pcw = 1; e_bub = 0; end
    chk("pc_write", 32'(pc_write), 32'(e_pcw));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    if (m_known) begin
      chk("instr_out", instr_out, m_instr);
      chk("pc4_out", pc4_out, m_pc4);
      chk("valid_out", 32'(valid_out), 32'(m_valid));
`ifdef IF_ID_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, 32'(m_stalls));
      chk("flush_count", flush_count, 32'(m_flushes));
`endif
    end
    if (!r) begin
      m_pc4 = 0; m_instr = 0; m_valid = 0; m_fp = 0; m_masked = 0; m_known = 1;
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e_pcw && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (fl) begin
        m_pc4 = 0; m_instr = 0; m_valid = 0; m_fp = 0; m_masked = 0;
        if (m_flushes < 64'hFFFF_FFFF) m_flushes++;
      end else if (es) begin
        m_fp = m_fp || bt;
      end else if (lu) begin
        m_masked = 1;
      end else begin
        m_pc4 = pc; m_instr = ins; m_valid = 1; m_masked = 0;
      end
    end
  endtask

  task automatic settle(input logic [31:0] ins);
    cyc(1, 32'h100, ins, 0, 0, 0, 0);
  endtask

  logic [5:0] ops [6];
  longint     fl_before, st_before;

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b000100; ops[2] = 6'b000101;
    ops[3] = 6'b101011; ops[4] = 6'b100011; ops[5] = 6'b001000;
    m_known = 0; m_masked = 0; m_fp = 0; m_valid = 0; m_pc4 = 0; m_instr = 0;
    m_stalls = 0; m_flushes = 0;

    // Reset then pass-through.
    cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    cyc(1, 32'h4, 32'h8C08_0004, 0, 0, 0, 0);
    cyc(1, 32'h8, 32'h0000_0000, 0, 0, 0, 0);
    chk("pass_instr", instr_out, 32'h8C08_0004);
    chk("pass_pc4", pc4_out, 32'h4);

    // Load-use: one stall, then masked on the second cycle.
    settle(32'h010A_4820);
    cyc(1, 32'h200, 32'h1111_1111, 1, 5'd8, 0, 0);
    chk("lu_pcw", 32'(pc_write), 32'd0);
    chk("lu_bub", 32'(idex_bubble), 32'd1);
    cyc(1, 32'h204, 32'h2222_2222, 1, 5'd8, 0, 0);
    chk("lu_hold", instr_out, 32'h010A_4820);
    chk("lu_masked_pcw", 32'(pc_write), 32'd1);

    // Zero register never stalls.
    settle(32'h0000_4820);
    cyc(1, 32'h300, 32'h0, 1, 5'd0, 0, 0);
    chk("zero_pcw", 32'(pc_write), 32'd1);

    // Store in decode reads rt; load in decode does not.
    settle(32'hAD28_0000);
    cyc(1, 32'h400, 32'h0, 1, 5'd8, 0, 0);
    chk("sw_rt_pcw", 32'(pc_write), 32'd0);
    settle(32'h8D28_0000);
    cyc(1, 32'h404, 32'h0, 1, 5'd8, 0, 0);
    chk("lw_rt_pcw", 32'(pc_write), 32'd1);

    // Branch flush.
    cyc(1, 32'h500, 32'h3333_3333, 0, 0, 1, 0);
    chk("br_bub", 32'(idex_bubble), 32'd1);
    chk("br_pcw", 32'(pc_write), 32'd1);
    cyc(1, 32'h504, 32'h4444_4444, 0, 0, 0, 0);
    chk("br_valid", 32'(valid_out), 32'd0);

    // Flush held across a freeze, applied once when it lifts.
    settle(32'h5555_5555);
    fl_before = m_flushes;
    cyc(1, 32'h600, 32'h0, 0, 0, 1, 1);
    cyc(1, 32'h600, 32'h0, 0, 0, 1, 1);
    cyc(1, 32'h600, 32'h0, 0, 0, 0, 1);
    chk("frz_pcw", 32'(pc_write), 32'd0);
    chk("frz_hold", instr_out, 32'h5555_5555);
    cyc(1, 32'h604, 32'h6666_6666, 0, 0, 0, 0);
    chk("frz_flush_bub", 32'(idex_bubble), 32'd1);
    cyc(1, 32'h608, 32'h7777_7777, 0, 0, 0, 0);
    chk("frz_valid", 32'(valid_out), 32'd0);
    chk("frz_single_flush", 32'(m_flushes - fl_before), 32'd1);

    // Branch and load-use together: flush only, FSM stays in RUN.
    settle(32'h010A_4820);
    st_before = m_stalls;
    cyc(1, 32'h700, 32'h0, 1, 5'd8, 1, 0);
    chk("both_pcw", 32'(pc_write), 32'd1);
    settle(32'h010A_4820);
    cyc(1, 32'h704, 32'h0, 1, 5'd8, 0, 0);
    chk("both_then_lu", 32'(pc_write), 32'd0);

    // Reset with a flush pending clears it.
    cyc(1, 32'h800, 32'h0, 0, 0, 1, 1);
    cyc(0, 32'h800, 32'h0, 0, 0, 0, 0);
    cyc(1, 32'h804, 32'h0, 0, 0, 0, 0);
    chk("rst_clr_bub", 32'(idex_bubble), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [4:0]  rt;
      int          sel;
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 5)];
      sel = $urandom_range(0, 3);
      rt = (sel == 0) ? m_instr[25:21] : (sel == 1) ? m_instr[20:16] : 5'($urandom);
      cyc(($urandom_range(0, 99) != 0), $urandom, ins, $urandom_range(0, 1) == 1, rt,
          $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
